adc_align_sched: RTL and testbench

- Sequences deserializer alignment across N_CH ADC channels, each checked by its own per-channel ramp checker.
- Puts the ADCs into ramp test-pattern mode over a config handshake, then starts one channel's ramp check at a time.
- Collects each pass/fail result, retries failed channels up to MAX_RETRY, then restores normal ADC mode.
- Sits between the slow-control / run-control logic and the per-channel ramp checkers.

---
 rtl/adc_align_pkg.sv | 30 +++
 rtl/adc_align_timer.sv | 42 ++++
 rtl/adc_align_sched.sv | 204 ++++++++++++++++++++
 tb/tb_adc_align_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_align_pkg.sv
// adc_align_pkg: shared types and constants for the ADC alignment scheduler.
//   state_e       - scheduler FSM states (3-bit encoding)
//   CFG_MODE_*    - values driven on cfg_mode
//   RETRY_W       - width of the per-channel retry counter
//   TIMER_W       - width of the shared wait/hold down-counter
//   ch_width()    - channel index width, never less than 1 bit
package adc_align_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCfgRamp,
      StInit,
      StWait,
      StHold,
      StNext,
      StCfgNorm,
      StDone
   } state_e;

   localparam logic CFG_MODE_RAMP = 1'b1;
   localparam logic CFG_MODE_NORM = 1'b0;

   localparam int unsigned RETRY_W = 4;
   localparam int unsigned TIMER_W = 16;

   function automatic int unsigned ch_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adc_align_timer.sv
// adc_align_timer: loadable down-counter shared by the end_ramp timeout and the
// post-failure settle hold.
// Ports:
//   clk, rstb  - clock, asynchronous active-low reset
//   load       - load counter with value (has priority over en)
//   value      - load value
//   en         - decrement by one per cycle, stopping at zero
//   expired    - high in the last counting cycle (count is 1) or when already 0
module adc_align_timer
   import adc_align_pkg::*;
(
   input  logic               clk,
   input  logic               rstb,
   input  logic               load,
   input  logic [TIMER_W-1:0] value,
   input  logic               en,
   output logic               expired
);

   logic [TIMER_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = value;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A load of N therefore yields exactly N counting cycles before expiry.
   assign expired = (cnt_q <= TIMER_W'(1));

endmodule

// File: rtl/adc_align_sched.sv
// adc_align_sched: sequences deserializer alignment across N_CH ADC channels.
// Switches the ADCs to ramp pattern, runs each channel's ramp checker in turn,
// retries failed channels up to MAX_RETRY times, then restores normal mode.
// Optional build macro: ALIGN_SCHED_CH_MASK_EN adds input ch_mask (sampled on an
// accepted start); masked channels are skipped entirely.
// Ports:
//   clk, rstb          - clock, asynchronous active-low reset
//   start              - request a full pass (ignored while busy)
//   ch_mask            - (macro only) channels to skip
//   init_o             - one-hot start pulse to the selected ramp checker
//   end_ramp_i         - per-channel end-of-check pulse
//   des_rst_i          - per-channel failure flag, valid with end_ramp_i
//   cfg_req, cfg_mode  - config request and mode (1 ramp, 0 normal)
//   cfg_ack            - config acknowledge
//   busy, done         - pass in progress, end-of-pass pulse
//   ch_ok, ch_fail     - sticky per-channel pass / final-failure flags
module adc_align_sched
   import adc_align_pkg::*;
#(
   parameter int unsigned N_CH      = 4,
   parameter int unsigned MAX_RETRY = 3,
   parameter logic [15:0] TIMEOUT   = 16'd16384,
   parameter logic [7:0]  RST_HOLD  = 8'd64
) (
   input  logic            clk,
   input  logic            rstb,
   input  logic            start,
`ifdef ALIGN_SCHED_CH_MASK_EN
   input  logic [N_CH-1:0] ch_mask,
`endif
   output logic [N_CH-1:0] init_o,
   input  logic [N_CH-1:0] end_ramp_i,
   input  logic [N_CH-1:0] des_rst_i,
   output logic            cfg_req,
   output logic            cfg_mode,
   input  logic            cfg_ack,
   output logic            busy,
   output logic            done,
   output logic [N_CH-1:0] ch_ok,
   output logic [N_CH-1:0] ch_fail
);

   localparam int unsigned CH_W = ch_width(N_CH);

   state_e              state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [RETRY_W-1:0]  retry_q, retry_d;
   logic [N_CH-1:0]     ok_q, ok_d, fail_q, fail_d;
   logic [N_CH-1:0]     mask;
   logic [N_CH-1:0]     ch_sel;
   logic                sel_end, sel_des;
   logic                first_vld, next_vld;
   logic [CH_W-1:0]     first_ch, next_ch;
   logic                tmr_load, tmr_en, tmr_expired;
   logic [TIMER_W-1:0]  tmr_val;

`ifdef ALIGN_SCHED_CH_MASK_EN
   logic [N_CH-1:0] mask_q;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         mask_q <= '0;
      end else if ((state_q == StIdle) && start) begin
         mask_q <= ch_mask;
      end
   end

   assign mask = mask_q;
`else
   assign mask = '0;
`endif

   adc_align_timer u_timer (
      .clk     (clk),
      .rstb    (rstb),
      .load    (tmr_load),
      .value   (tmr_val),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   assign ch_sel  = N_CH'(1) << ch_q;
   assign sel_end = |(end_ramp_i & ch_sel);
   assign sel_des = |(des_rst_i & ch_sel);

   // Lowest unmasked channel overall and lowest unmasked channel above ch_q;
   // scanning downwards lets the lowest match overwrite the others.
   always_comb begin
      first_vld = 1'b0;
      first_ch  = '0;
      next_vld  = 1'b0;
      next_ch   = '0;
      for (int i = int'(N_CH) - 1; i >= 0; i--) begin
         if (!mask[i]) begin
            first_vld = 1'b1;
            first_ch  = CH_W'(i);
            if (i > int'(ch_q)) begin
               next_vld = 1'b1;
               next_ch  = CH_W'(i);
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      retry_d  = retry_q;
      ok_d     = ok_q;
      fail_d   = fail_q;
      tmr_load = 1'b0;
      tmr_val  = TIMEOUT;
      tmr_en   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               ok_d    = '0;
               fail_d  = '0;
               state_d = StCfgRamp;
            end
         end
         StCfgRamp: begin
            if (cfg_ack) begin
               ch_d    = first_ch;
               retry_d = '0;
               state_d = first_vld ? StInit : StCfgNorm;
            end
         end
         StInit: begin
            tmr_load = 1'b1;
            state_d  = StWait;
         end
         StWait: begin
            tmr_en = 1'b1;
            // A checker answer in the expiry cycle still counts.
            if (sel_end || tmr_expired) begin
               if (sel_end && !sel_des) begin
                  ok_d    = ok_q | ch_sel;
                  state_d = StNext;
               end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                  retry_d  = (retry_q == '1) ? retry_q : retry_q + 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = TIMER_W'(RST_HOLD);
                  state_d  = StHold;
               end else begin
                  fail_d  = fail_q | ch_sel;
                  state_d = StNext;
               end
            end
         end
         StHold: begin
            tmr_en = 1'b1;
            if (tmr_expired) begin
               state_d = StInit;
            end
         end
         StNext: begin
            retry_d = '0;
            if (next_vld) begin
               ch_d    = next_ch;
               state_d = StInit;
            end else begin
               state_d = StCfgNorm;
            end
         end
         StCfgNorm: begin
            if (cfg_ack) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= StIdle;
         ch_q    <= '0;
         retry_q <= '0;
         ok_q    <= '0;
         fail_q  <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         retry_q <= retry_d;
         ok_q    <= ok_d;
         fail_q  <= fail_d;
      end
   end

   assign init_o   = (state_q == StInit) ? ch_sel : '0;
   assign cfg_req  = (state_q == StCfgRamp) || (state_q == StCfgNorm);
   assign cfg_mode = (state_q == StCfgRamp) ? CFG_MODE_RAMP : CFG_MODE_NORM;
   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StDone);
   assign ch_ok    = ok_q;
   assign ch_fail  = fail_q;

endmodule

// File: tb/tb_adc_align_sched.sv
`timescale 1ns/1ps
module tb_adc_align_sched;

   localparam int unsigned N_CH      = 4;
   localparam int unsigned MAX_RETRY = 3;
   localparam logic [15:0] TIMEOUT   = 16'd50;
   localparam logic [7:0]  RST_HOLD  = 8'd20;
   localparam int          TO        = 50;
   localparam int          RH        = 20;
   localparam int          BUDGET    = 3000;
`ifdef ALIGN_SCHED_CH_MASK_EN
   localparam int          N_VEC     = 8;
`else
   localparam int          N_VEC     = 6;
`endif

   logic            clk = 1'b0;
   logic            rstb = 1'b0;
   logic            start = 1'b0;
   logic [N_CH-1:0] init_o;
   logic [N_CH-1:0] end_ramp_i = '0;
   logic [N_CH-1:0] des_rst_i = '0;
   logic            cfg_req, cfg_mode, busy, done;
   logic            cfg_ack = 1'b0;
   logic [N_CH-1:0] ch_ok, ch_fail;
`ifdef ALIGN_SCHED_CH_MASK_EN
   logic [N_CH-1:0] ch_mask = '0;
`endif

   always #5 clk = ~clk;

   adc_align_sched #(
      .N_CH      (N_CH),
      .MAX_RETRY (MAX_RETRY),
      .TIMEOUT   (TIMEOUT),
      .RST_HOLD  (RST_HOLD)
   ) dut (
      .clk        (clk),
      .rstb       (rstb),
      .start      (start),
`ifdef ALIGN_SCHED_CH_MASK_EN
      .ch_mask    (ch_mask),
`endif
      .init_o     (init_o),
      .end_ramp_i (end_ramp_i),
      .des_rst_i  (des_rst_i),
      .cfg_req    (cfg_req),
      .cfg_mode   (cfg_mode),
      .cfg_ack    (cfg_ack),
      .busy       (busy),
      .done       (done),
      .ch_ok      (ch_ok),
      .ch_fail    (ch_fail)
   );

   // One pass scenario: per-channel checker behaviour plus expected results.
   // Packed per-channel fields are indexed [ch]; literals read ch3..ch0.
   typedef struct packed {
      logic [3:0]      mask;
      logic [3:0][3:0] nfail;     // failing attempts before a pass (15 = never passes)
      logic [3:0]      silent;    // failing attempts give no end_ramp at all
      logic [3:0][7:0] lat;       // cycles from init_o to end_ramp_i
      logic [7:0]      ack_dly;   // cycles from cfg_req rise to cfg_ack
      logic [3:0]      exp_ok;
      logic [3:0]      exp_fail;
      logic [7:0]      exp_inits;
   } vec_t;

   vec_t cur;
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   sb[$];                   // expected init_o channel order
   int   att [N_CH];
   int   exp_init_cyc = -1;
   int   n_cfg, n_done, n_init;
   bit   pend, pend_drive, pend_fail;
   int   pend_cyc, pend_ch, pend_init;
   bit   req_on, req_bad, req_mode;
   int   req_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Checker / config-master model and scoreboard consumer, active at negedge.
   initial begin : responder
      int c;
      int e;
      forever begin
         @(negedge clk);
         end_ramp_i = '0;
         des_rst_i  = '0;
         cfg_ack    = 1'b0;
         if (!rstb) begin
            pend         = 1'b0;
            req_on       = 1'b0;
            exp_init_cyc = -1;
         end else begin
            if (done) n_done++;
            if (req_on) begin
               if (cyc <= req_cyc + int'(cur.ack_dly)) begin
                  if (!cfg_req || (cfg_mode != req_mode)) req_bad = 1'b1;
                  if (cyc == req_cyc + int'(cur.ack_dly)) cfg_ack = 1'b1;
               end else begin
                  check("cfg_req_held", 32'(req_bad), 32'd0);
                  check("cfg_req_drop", 32'(cfg_req && (cfg_mode == req_mode)), 32'd0);
                  req_on = 1'b0;
                  if (n_cfg == 1) exp_init_cyc = cyc;
               end
            end
            if (!req_on && cfg_req) begin
               req_on   = 1'b1;
               req_cyc  = cyc;
               req_mode = cfg_mode;
               req_bad  = 1'b0;
               n_cfg++;
               check("cfg_mode_order", 32'(cfg_mode), (n_cfg == 1) ? 32'd1 : 32'd0);
            end else if (!busy && !cfg_req && (cyc % 4 == 0)) begin
               cfg_ack = 1'b1;   // stray ack while nothing is requested
            end
            if (init_o != '0) begin
               n_init++;
               c = 0;
               for (int i = 0; i < int'(N_CH); i++) if (init_o[i]) c = i;
               if (sb.size() == 0) begin
                  check("init_unexpected", 32'(init_o), 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("init_channel", 32'(init_o), 32'd1 << e);
               end
               if (exp_init_cyc >= 0) check("init_cycle", 32'(cyc), 32'(exp_init_cyc));
               exp_init_cyc = -1;
               att[c]++;
               pend       = 1'b1;
               pend_ch    = c;
               pend_init  = cyc;
               pend_fail  = (att[c] <= int'(cur.nfail[c]));
               pend_drive = !(pend_fail && cur.silent[c]);
               pend_cyc   = pend_drive ? cyc + int'(cur.lat[c]) : cyc + TO;
            end else if (pend) begin
               if (cyc == pend_init + 3) begin
                  // failing answer on a channel that is not selected
                  end_ramp_i[(pend_ch + 1) % int'(N_CH)] = 1'b1;
                  des_rst_i[(pend_ch + 1) % int'(N_CH)]  = 1'b1;
               end
               if (cyc == pend_cyc) begin
                  if (pend_drive) begin
                     end_ramp_i[pend_ch] = 1'b1;
                     des_rst_i[pend_ch]  = pend_fail;
                  end
                  pend = 1'b0;
                  exp_init_cyc = (pend_fail && (att[pend_ch] <= int'(MAX_RETRY))) ?
                                 cyc + RH + 1 : cyc + 2;
               end
            end
         end
      end
   end

   task automatic setup(input vec_t v);
      cur = v;
      sb.delete();
      for (int i = 0; i < int'(N_CH); i++) begin
         int n;
         att[i] = 0;
         n = ((int'(v.nfail[i]) < int'(MAX_RETRY)) ? int'(v.nfail[i]) : int'(MAX_RETRY)) + 1;
         if (!v.mask[i]) repeat (n) sb.push_back(i);
      end
      exp_init_cyc = -1;
      n_cfg  = 0;
      n_done = 0;
      n_init = 0;
   endtask

   task automatic start_pass(input vec_t v);
      setup(v);
      @(negedge clk);
`ifdef ALIGN_SCHED_CH_MASK_EN
      ch_mask = v.mask;
`endif
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("flags_cleared", 32'({ch_ok, ch_fail}), 32'd0);
   endtask

   task automatic finish_pass(input vec_t v, input int idx);
      bit seen = 1'b0;
      for (int k = 0; k < BUDGET; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
         start = (k == 5) || (k == 40);   // must be ignored while busy
      end
      start = 1'b0;
      check($sformatf("v%0d_done_seen", idx), 32'(seen), 32'd1);
      check($sformatf("v%0d_ch_ok", idx), 32'(ch_ok), 32'(v.exp_ok));
      check($sformatf("v%0d_ch_fail", idx), 32'(ch_fail), 32'(v.exp_fail));
      @(negedge clk);
      check($sformatf("v%0d_idle_after_done", idx), 32'({busy, done, cfg_req, init_o}), 32'd0);
      check($sformatf("v%0d_done_count", idx), 32'(n_done), 32'd1);
      check($sformatf("v%0d_init_count", idx), 32'(n_init), 32'(v.exp_inits));
      check($sformatf("v%0d_sb_empty", idx), 32'(sb.size()), 32'd0);
      check($sformatf("v%0d_cfg_count", idx), 32'(n_cfg), 32'd2);
   endtask

   initial begin : main
      vec_t vecs [N_VEC];
      // all pass
      vecs[0] = '{mask: 4'h0, nfail: 16'h0000, silent: 4'h0, lat: 32'h1E1E1E1E,
                  ack_dly: 8'd1, exp_ok: 4'hF, exp_fail: 4'h0, exp_inits: 8'd4};
      // ch1 fails twice then passes
      vecs[1] = '{mask: 4'h0, nfail: 16'h0020, silent: 4'h0, lat: 32'h1E1E1E1E,
                  ack_dly: 8'd3, exp_ok: 4'hF, exp_fail: 4'h0, exp_inits: 8'd6};
      // ch2 always fails: retries exhausted
      vecs[2] = '{mask: 4'h0, nfail: 16'h0F00, silent: 4'h0, lat: 32'h1E1E1E1E,
                  ack_dly: 8'd1, exp_ok: 4'hB, exp_fail: 4'h4, exp_inits: 8'd7};
      // ch0 silent once, then answers in the expiry cycle
      vecs[3] = '{mask: 4'h0, nfail: 16'h0001, silent: 4'h1, lat: 32'h1E1E1E32,
                  ack_dly: 8'd1, exp_ok: 4'hF, exp_fail: 4'h0, exp_inits: 8'd5};
      // slow config acknowledge
      vecs[4] = '{mask: 4'h0, nfail: 16'h0000, silent: 4'h0, lat: 32'h0A0A0A0A,
                  ack_dly: 8'd20, exp_ok: 4'hF, exp_fail: 4'h0, exp_inits: 8'd4};
      // ch3 never answers: every attempt times out
      vecs[5] = '{mask: 4'h0, nfail: 16'hF000, silent: 4'h8, lat: 32'h1E1E1E1E,
                  ack_dly: 8'd2, exp_ok: 4'h7, exp_fail: 4'h8, exp_inits: 8'd7};
`ifdef ALIGN_SCHED_CH_MASK_EN
      vecs[6] = '{mask: 4'h5, nfail: 16'h0000, silent: 4'h0, lat: 32'h1E1E1E1E,
                  ack_dly: 8'd1, exp_ok: 4'hA, exp_fail: 4'h0, exp_inits: 8'd2};
      vecs[7] = '{mask: 4'hF, nfail: 16'h0000, silent: 4'h0, lat: 32'h1E1E1E1E,
                  ack_dly: 8'd2, exp_ok: 4'h0, exp_fail: 4'h0, exp_inits: 8'd0};
`endif

      rstb = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs",
            32'({init_o, cfg_req, cfg_mode, busy, done, ch_ok, ch_fail}), 32'd0);
      rstb = 1'b1;
      repeat (8) @(negedge clk);
      check("idle_ignores_ack", 32'({busy, cfg_req}), 32'd0);

      for (int i = 0; i < N_VEC; i++) begin
         start_pass(vecs[i]);
         finish_pass(vecs[i], i);
         repeat (3) @(negedge clk);
      end

      // Reset in the middle of ch2's wait, then a fresh pass from ch0.
      start_pass(vecs[0]);
      for (int k = 0; k < BUDGET; k++) begin
         @(negedge clk);
         if (init_o[2]) break;
      end
      repeat (5) @(negedge clk);
      check("ok_before_reset", 32'(ch_ok), 32'h3);
      #2 rstb = 1'b0;
      #1;
      check("async_reset_outputs",
            32'({init_o, cfg_req, cfg_mode, busy, done, ch_ok, ch_fail}), 32'd0);
      repeat (3) @(negedge clk);
      rstb = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_reset", 32'({busy, done}), 32'd0);
      start_pass(vecs[0]);
      finish_pass(vecs[0], 99);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
